// File: rtl/lock_sequencer_if.sv
// rtl/lock_sequencer_if.sv - keypad inputs and status outputs of the lock sequencer
interface lock_sequencer_if;
    logic [4:0] keycode;
    logic       newkey;
    logic [2:0] whichState;
    logic       open;
    logic       error;
    logic       lockout;

    modport master (
        output keycode,
        output newkey,
        input  whichState,
        input  open,
        input  error,
        input  lockout
    );

    modport slave (
        input  keycode,
        input  newkey,
        output whichState,
        output open,
        output error,
        output lockout
    );
endinterface

// File: rtl/lock_sequencer.sv
// rtl/lock_sequencer.sv - four-digit combination entry, check, open window and lockout
module lock_sequencer #(
    parameter logic [3:0] CODE0          = 4'd1,
    parameter logic [3:0] CODE1          = 4'd2,
    parameter logic [3:0] CODE2          = 4'd9,
    parameter logic [3:0] CODE3          = 4'd6,
    parameter int         TIMEOUT        = 16,
    parameter int         OPEN_CYCLES    = 8,
    parameter int         MAX_FAILS      = 3,
    parameter int         LOCKOUT_CYCLES = 32
) (
    input  logic              clk5,
    input  logic              reset,
    lock_sequencer_if.slave   bus
);

    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam int OW = $clog2(OPEN_CYCLES) + 1;
    localparam int FW = $clog2(MAX_FAILS) + 1;
    localparam int LW = $clog2(LOCKOUT_CYCLES) + 1;

    localparam logic [TW-1:0] KEY_LAST  = TW'(TIMEOUT - 1);
    localparam logic [OW-1:0] OPEN_LAST = OW'(OPEN_CYCLES - 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);
    localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAILS);

    // Encoding doubles as the whichState status value.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ENTRY1 = 3'd1,
        S_ENTRY2 = 3'd2,
        S_ENTRY3 = 3'd3,
        S_CHECK  = 3'd4,
        S_OPEN   = 3'd5,
        S_FAIL   = 3'd6,
        S_LOCK   = 3'd7
    } state_t;

    state_t        state;
    state_t        next_state;
    logic          newkey_d;
    logic          key_event;
    logic [3:0]    code_digit;
    logic          digit_ok;
    logic          match;
    logic          match_next;
    logic [FW-1:0] fail_cnt;
    logic [FW-1:0] fail_next;
    logic [TW-1:0] key_tmr;
    logic [TW-1:0] key_tmr_next;
    logic [OW-1:0] open_tmr;
    logic [OW-1:0] open_tmr_next;
    logic [LW-1:0] lock_tmr;
    logic [LW-1:0] lock_tmr_next;
    logic          open_q;
    logic          error_q;
    logic          lockout_q;

    // A held key is one event: only the rising edge of newkey with a valid flag counts.
    assign key_event = bus.newkey & ~newkey_d & bus.keycode[4];

    // Expected digit for the position about to be filled.
    always_comb begin
        code_digit = CODE0;
        case (state)
            S_ENTRY1: code_digit = CODE1;
            S_ENTRY2: code_digit = CODE2;
            S_ENTRY3: code_digit = CODE3;
            default:  code_digit = CODE0;
        endcase
    end

    assign digit_ok = (bus.keycode[3:0] == code_digit);

    // Next-state, match accumulation, fail counting and timer updates.
    always_comb begin
        next_state    = state;
        match_next    = match;
        fail_next     = fail_cnt;
        key_tmr_next  = key_tmr;
        open_tmr_next = open_tmr;
        lock_tmr_next = lock_tmr;
        case (state)
            S_IDLE: begin
                if (key_event) begin
                    next_state   = S_ENTRY1;
                    match_next   = digit_ok;
                    key_tmr_next = '0;
                end
            end
            S_ENTRY1, S_ENTRY2, S_ENTRY3: begin
                // A key on the expiry edge wins over the timeout.
                if (key_event) begin
                    case (state)
                        S_ENTRY1: next_state = S_ENTRY2;
                        S_ENTRY2: next_state = S_ENTRY3;
                        default:  next_state = S_CHECK;
                    endcase
                    match_next   = match & digit_ok;
                    key_tmr_next = '0;
                end else if (key_tmr == KEY_LAST) begin
                    next_state   = S_IDLE;
                    match_next   = 1'b0;
                    key_tmr_next = '0;
                end else begin
                    key_tmr_next = key_tmr + TW'(1);
                end
            end
            S_CHECK: begin
                key_tmr_next = '0;
                if (match) begin
                    next_state    = S_OPEN;
                    fail_next     = '0;
                    open_tmr_next = '0;
                end else begin
                    next_state = S_FAIL;
                    if (fail_cnt != FAIL_MAX) begin
                        fail_next = fail_cnt + FW'(1);
                    end
                end
            end
            S_OPEN: begin
                if (open_tmr == OPEN_LAST) begin
                    next_state    = S_IDLE;
                    open_tmr_next = '0;
                end else begin
                    open_tmr_next = open_tmr + OW'(1);
                end
            end
            S_FAIL: begin
                if (fail_cnt == FAIL_MAX) begin
                    next_state    = S_LOCK;
                    lock_tmr_next = '0;
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_LOCK: begin
                if (lock_tmr == LOCK_LAST) begin
                    next_state    = S_IDLE;
                    fail_next     = '0;
                    lock_tmr_next = '0;
                end else begin
                    lock_tmr_next = lock_tmr + LW'(1);
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // State, counters and the key-edge register.
    always_ff @(posedge clk5 or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            newkey_d <= 1'b0;
            match    <= 1'b0;
            fail_cnt <= '0;
            key_tmr  <= '0;
            open_tmr <= '0;
            lock_tmr <= '0;
        end else begin
            state    <= next_state;
            newkey_d <= bus.newkey;
            match    <= match_next;
            fail_cnt <= fail_next;
            key_tmr  <= key_tmr_next;
            open_tmr <= open_tmr_next;
            lock_tmr <= lock_tmr_next;
        end
    end

    // Output flags registered alongside the state so they change on the same edge.
    always_ff @(posedge clk5 or posedge reset) begin
        if (reset) begin
            open_q    <= 1'b0;
            error_q   <= 1'b0;
            lockout_q <= 1'b0;
        end else begin
            open_q    <= (next_state == S_OPEN);
            error_q   <= (next_state == S_FAIL);
            lockout_q <= (next_state == S_LOCK);
        end
    end

    assign bus.whichState = state;
    assign bus.open       = open_q;
    assign bus.error      = error_q;
    assign bus.lockout    = lockout_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// tb/tb_lock_sequencer.sv - table-driven bench for lock_sequencer
module tb_lock_sequencer;

    typedef struct {
        logic       nk;
        logic [4:0] kc;
        logic [2:0] ws;
        logic       o;
        logic       e;
        logic       l;
        string      name;
    } vec_t;

    logic clk5;
    logic reset;
    int   passed;
    int   total;
    vec_t vecs[$];

    lock_sequencer_if bus ();

    lock_sequencer dut (
        .clk5  (clk5),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk5 = 1'b0;
    always #5 clk5 = ~clk5;

    function automatic void add(input logic nk, input logic [4:0] kc, input logic [2:0] ws,
                                input logic o, input logic e, input logic l, input string name);
        vec_t v;
        v.nk = nk; v.kc = kc; v.ws = ws; v.o = o; v.e = e; v.l = l; v.name = name;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [2:0] ws, input logic o,
                       input logic e, input logic l);
        total++;
        if ({bus.whichState, bus.open, bus.error, bus.lockout} !== {ws, o, e, l}) begin
            $display("FAIL %s: got ws=%0d open=%b error=%b lockout=%b, want ws=%0d open=%b error=%b lockout=%b",
                     name, bus.whichState, bus.open, bus.error, bus.lockout, ws, o, e, l);
        end else begin
            passed++;
        end
    endtask

    // One clock: drive on the falling edge, check just after the rising edge.
    task automatic cyc(input logic nk, input logic [4:0] kc, input logic [2:0] ws,
                       input logic o, input logic e, input logic l, input string name);
        @(negedge clk5);
        bus.newkey  = nk;
        bus.keycode = kc;
        @(posedge clk5);
        #1;
        chk(name, ws, o, e, l);
    endtask

    // Keys 1,2,9,last with one idle cycle between; ends on the edge of the fourth key.
    task automatic enter_code(input logic [3:0] last, input bit locked);
        logic [4:0] k [4];
        k[0] = 5'h11; k[1] = 5'h12; k[2] = 5'h19; k[3] = {1'b1, last};
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, k[i], locked ? 3'd7 : 3'(i + 1), 1'b0, 1'b0, locked, "code_key");
            if (i < 3) cyc(1'b0, 5'h00, locked ? 3'd7 : 3'(i + 1), 1'b0, 1'b0, locked, "code_gap");
        end
    endtask

    task automatic wait_timeout(input logic [2:0] ws);
        for (int i = 0; i < 15; i++) cyc(1'b0, 5'h00, ws, 1'b0, 1'b0, 1'b0, "timeout_wait");
        cyc(1'b0, 5'h00, 3'd0, 1'b0, 1'b0, 1'b0, "timeout_expire");
    endtask

    initial begin
        passed = 0;
        total  = 0;
        bus.newkey  = 1'b0;
        bus.keycode = 5'h00;
        reset = 1'b1;

        // Correct code, then the open window.
        add(1, 5'h11, 1, 0, 0, 0, "ok_d0");   add(0, 5'h00, 1, 0, 0, 0, "ok_gap0");
        add(1, 5'h12, 2, 0, 0, 0, "ok_d1");   add(0, 5'h00, 2, 0, 0, 0, "ok_gap1");
        add(1, 5'h19, 3, 0, 0, 0, "ok_d2");   add(0, 5'h00, 3, 0, 0, 0, "ok_gap2");
        add(1, 5'h16, 4, 0, 0, 0, "ok_check");
        for (int i = 0; i < 8; i++) add(0, 5'h00, 5, 1, 0, 0, "open_window");
        add(0, 5'h00, 0, 0, 0, 0, "open_end");
        // Wrong last digit: CHECK, one-cycle error, back to idle.
        add(1, 5'h11, 1, 0, 0, 0, "bad_d0");  add(0, 5'h00, 1, 0, 0, 0, "bad_gap0");
        add(1, 5'h12, 2, 0, 0, 0, "bad_d1");  add(0, 5'h00, 2, 0, 0, 0, "bad_gap1");
        add(1, 5'h19, 3, 0, 0, 0, "bad_d2");  add(0, 5'h00, 3, 0, 0, 0, "bad_gap2");
        add(1, 5'h17, 4, 0, 0, 0, "bad_check");
        add(0, 5'h00, 6, 0, 1, 0, "bad_fail");
        add(0, 5'h00, 0, 0, 0, 0, "bad_idle");
        add(0, 5'h00, 0, 0, 0, 0, "bad_idle2");

        repeat (2) @(posedge clk5);
        #1;
        chk("reset_state", 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk5);
        reset = 1'b0;

        foreach (vecs[i]) cyc(vecs[i].nk, vecs[i].kc, vecs[i].ws, vecs[i].o, vecs[i].e, vecs[i].l, vecs[i].name);

        // Second and third consecutive failures; the third locks out.
        enter_code(4'd7, 1'b0);
        cyc(0, 5'h00, 6, 0, 1, 0, "fail2");
        cyc(0, 5'h00, 0, 0, 0, 0, "fail2_idle");
        enter_code(4'd7, 1'b0);
        cyc(0, 5'h00, 6, 0, 1, 0, "fail3");
        cyc(0, 5'h00, 7, 0, 0, 1, "lock_enter");
        enter_code(4'd6, 1'b1);
        for (int i = 0; i < 24; i++) cyc(0, 5'h00, 7, 0, 0, 1, "lock_hold");
        cyc(0, 5'h00, 0, 0, 0, 0, "lock_end");
        enter_code(4'd6, 1'b0);
        for (int i = 0; i < 8; i++) cyc(0, 5'h00, 5, 1, 0, 0, "open_after_lock");
        cyc(0, 5'h00, 0, 0, 0, 0, "open_after_lock_end");

        // Inter-key timeout, and a key landing on the expiry edge.
        cyc(1, 5'h11, 1, 0, 0, 0, "to_key");
        wait_timeout(3'd1);
        cyc(1, 5'h11, 1, 0, 0, 0, "exp_key0");
        for (int i = 0; i < 15; i++) cyc(0, 5'h00, 1, 0, 0, 0, "exp_wait");
        cyc(1, 5'h12, 2, 0, 0, 0, "expiry_edge_key");
        wait_timeout(3'd2);

        // Held key gives one digit; invalid flag never counts.
        cyc(1, 5'h01, 0, 0, 0, 0, "invalid_idle");
        cyc(0, 5'h00, 0, 0, 0, 0, "invalid_idle_gap");
        for (int i = 0; i < 5; i++) cyc(1, 5'h11, 1, 0, 0, 0, "held_key");
        cyc(0, 5'h00, 1, 0, 0, 0, "held_release");
        cyc(1, 5'h01, 1, 0, 0, 0, "invalid_entry");
        cyc(0, 5'h00, 1, 0, 0, 0, "invalid_entry_gap");
        cyc(1, 5'h12, 2, 0, 0, 0, "after_held");
        wait_timeout(3'd2);

        // Reset during OPEN drops outputs without a clock edge.
        enter_code(4'd6, 1'b0);
        cyc(0, 5'h00, 5, 1, 0, 0, "pre_reset_open");
        cyc(0, 5'h00, 5, 1, 0, 0, "pre_reset_open2");
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_open", 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk5);
        reset = 1'b0;

        // Reset clears the fail counter: two failures, reset, one more must not lock.
        for (int a = 0; a < 2; a++) begin
            enter_code(4'd7, 1'b0);
            cyc(0, 5'h00, 6, 0, 1, 0, "prefail");
            cyc(0, 5'h00, 0, 0, 0, 0, "prefail_idle");
        end
        @(negedge clk5);
        reset = 1'b1;
        @(negedge clk5);
        reset = 1'b0;
        enter_code(4'd7, 1'b0);
        cyc(0, 5'h00, 6, 0, 1, 0, "postreset_fail");
        cyc(0, 5'h00, 0, 0, 0, 0, "postreset_no_lock");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
